// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the multi_timer register window.
//   - Byte offsets of the global registers (counter, acknowledge, status).
//   - Per-channel layout: compare_i at CH_BASE + CH_STRIDE*i, period_i 4 bytes
//     above its compare register.
//   - compare_reset_value(): all-ones of the configured counter width,
//     zero-extended to 32 bits.
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam logic [31:0] OFF_COUNTER = 32'h0000_0000;
  localparam logic [31:0] OFF_ACK     = 32'h0000_0004;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0008;
  localparam logic [31:0] OFF_CH_BASE = 32'h0000_0010;
  localparam logic [31:0] CH_STRIDE   = 32'h0000_0008;
  localparam logic [31:0] OFF_PERIOD  = 32'h0000_0004;

  // All-ones value for a counter of the given width.
  function automatic logic [31:0] compare_reset_value(input int width);
    if (width >= 32) begin
      return 32'hffff_ffff;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

  // Byte offset of compare register for channel ch.
  function automatic logic [31:0] ch_compare_off(input int ch);
    return OFF_CH_BASE + CH_STRIDE * 32'(ch);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
// One compare channel of multi_timer: compare and period registers, the
// sticky pending flag, match detection and the periodic reload.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset
//   counter     shared free-running counter (pre-edge value)
//   compare_we  load compare from wdata at this edge
//   period_we   load period from wdata at this edge
//   ack         clear pending at this edge (a simultaneous match wins)
//   wdata       bus write data, already truncated to WIDTH
//   compare     current compare value
//   period      current period value (0 = one-shot)
//   pending     sticky interrupt flag
// -----------------------------------------------------------------------------
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] counter,
  input  logic             compare_we,
  input  logic             period_we,
  input  logic             ack,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] compare,
  output logic [WIDTH-1:0] period,
  output logic             pending
);

  localparam logic [WIDTH-1:0] COMPARE_RST = WIDTH'(compare_reset_value(WIDTH));

  logic match;

  // Match uses the counter value before the edge, so a counter load in the
  // same cycle never produces a match on its own.
  assign match = (counter == compare);

  always_ff @(posedge clock) begin
    if (reset) begin
      compare <= COMPARE_RST;
      period  <= '0;
      pending <= 1'b0;
    end else begin
      // A bus write of compare overrides a coincident reload.
      if (compare_we) begin
        compare <= wdata;
      end else if (match && (period != '0)) begin
        compare <= compare + period;
      end
      if (period_we) begin
        period <= wdata;
      end
      // Set wins over a coincident acknowledge.
      pending <= match | (pending & ~ack);
    end
  end

endmodule

// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
// Free-running counter with NUM_CH compare channels behind a memory-mapped
// register window at BASE_ADDR.
// Ports:
//   clock           rising-edge clock
//   reset           synchronous active-high reset
//   address         bus byte address
//   data            bus write data
//   MemRead         read strobe
//   MemWrite        write strobe
//   cycle           read data; Z unless a decoded read is in progress
//   TimerAddress    address hits a decoded register (strobe independent)
//   TimerInterrupt  per-channel sticky pending flags
//
// Bus protocol: single-cycle strobes with no ready/wait handshake. A write
// commits at the rising edge where MemWrite is high and the address decodes;
// a read is purely combinational and valid on cycle while MemRead is high and
// the address decodes. Undecoded accesses are ignored and leave cycle at Z.
// -----------------------------------------------------------------------------
module multi_timer
  import timer_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hffff_0100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic [31:0]       data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [31:0]       cycle,
  output logic              TimerAddress,
  output logic [NUM_CH-1:0] TimerInterrupt
);

  // One past the last decoded byte offset.
  localparam logic [31:0] WINDOW_END = OFF_CH_BASE + CH_STRIDE * 32'(NUM_CH);

  logic [31:0]       offset;
  logic              hit;
  logic              wr;
  logic [WIDTH-1:0]  counter;
  logic [NUM_CH-1:0] ack_bits;
  logic [NUM_CH-1:0] pending;
  logic [WIDTH-1:0]  compare_q [NUM_CH];
  logic [WIDTH-1:0]  period_q  [NUM_CH];
  logic [31:0]       rdata;

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  assign offset = address - BASE_ADDR;
  assign hit    = (offset < WINDOW_END) && (offset[1:0] == 2'b00) &&
                  (offset != 32'h0000_000c);
  assign wr     = MemWrite & hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      counter <= '0;
    end else if (wr && (offset == OFF_COUNTER)) begin
      counter <= data[WIDTH-1:0];
    end else begin
      counter <= counter + WIDTH'(1);
    end
  end

  assign ack_bits = (wr && (offset == OFF_ACK)) ? data[NUM_CH-1:0] : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [31:0] CMP_OFF = ch_compare_off(i);

    timer_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clock      (clock),
      .reset      (reset),
      .counter    (counter),
      .compare_we (wr && (offset == CMP_OFF)),
      .period_we  (wr && (offset == CMP_OFF + OFF_PERIOD)),
      .ack        (ack_bits[i]),
      .wdata      (data[WIDTH-1:0]),
      .compare    (compare_q[i]),
      .period     (period_q[i]),
      .pending    (pending[i])
    );
  end

  // Acknowledge and undecoded offsets read as zero.
  always_comb begin
    rdata = '0;
    if (offset == OFF_COUNTER) begin
      rdata = 32'(counter);
    end else if (offset == OFF_STATUS) begin
      rdata = 32'(pending);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (offset == ch_compare_off(i)) begin
        rdata = 32'(compare_q[i]);
      end
      if (offset == ch_compare_off(i) + OFF_PERIOD) begin
        rdata = 32'(period_q[i]);
      end
    end
  end

  assign cycle          = (MemRead && hit) ? rdata : {32{1'bz}};
  assign TimerAddress   = hit;
  assign TimerInterrupt = pending;

endmodule
